// File: rtl/light_sample_scheduler.sv
// light_sample_scheduler: periodically starts the SPI light-sensor master, watches SS for
// completion, extracts an 8-bit sample from the shifted word and drives a thermometer LED bar.
// A hung transfer (no SS ack, or SS stuck low) is recovered by pulsing spi_rst.
// Optional feature macro: LIGHT_AVG_EN -- light_level becomes the mean of the last 4 samples.
module light_sample_scheduler #(
   parameter int unsigned PERIOD_CYCLES  = 1_000_000,
   parameter int unsigned ACK_TIMEOUT    = 16,
   parameter int unsigned XFER_TIMEOUT   = 8192,
   parameter int unsigned RECOVER_CYCLES = 4,
   parameter int unsigned DATA_LSB       = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        spi_start,
   output logic        spi_rst,
   input  logic        spi_ss,
   input  logic [15:0] spi_word,
   output logic [7:0]  light_level,
   output logic        level_valid,
   output logic [7:0]  led_bar,
   output logic [7:0]  timeout_cnt
);

   localparam int unsigned CNT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned WD_MAX = (XFER_TIMEOUT > ACK_TIMEOUT)
                                    ? ((XFER_TIMEOUT > RECOVER_CYCLES) ? XFER_TIMEOUT : RECOVER_CYCLES)
                                    : ((ACK_TIMEOUT > RECOVER_CYCLES) ? ACK_TIMEOUT : RECOVER_CYCLES);
   localparam int unsigned WD_W   = $clog2(WD_MAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_LO,
      S_WAIT_HI,
      S_CAPTURE,
      S_RECOVER
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [7:0]       sample_q, sample_d;
   logic [7:0]       level_q, level_d;
   logic [7:0]       led_q, led_d;
   logic             valid_q, valid_d;
   logic [7:0]       tcnt_q, tcnt_d;
   logic             start_q, start_d;
   logic             rst_q, rst_d;
   logic             tick_c;
`ifdef LIGHT_AVG_EN
   logic [2:0][7:0]  hist_q, hist_d;
`endif

   // Only the sample field of the word is used; fold the rest into a sink.
   logic unused_word;
   assign unused_word = ^spi_word;

   // Thermometer code: n+1 ones from the LSB.
   function automatic logic [7:0] thermo(input logic [2:0] n);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) begin
         t[i] = (3'(i) <= n);
      end
      return t;
   endfunction

   // Next-state, period counter, watchdog and output computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      wd_d     = wd_q;
      sample_d = sample_q;
      level_d  = level_q;
      led_d    = led_q;
      valid_d  = 1'b0;
      tcnt_d   = tcnt_q;
`ifdef LIGHT_AVG_EN
      hist_d   = hist_q;
`endif
      tick_c   = enable && (cnt_q == CNT_W'(PERIOD_CYCLES - 1));
      if (enable) begin
         cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (tick_c && spi_ss) begin
               state_d = S_START;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!spi_ss) begin
               wd_d    = '0;
               state_d = S_WAIT_HI;
            end else if (wd_q == WD_W'(ACK_TIMEOUT - 1)) begin
               wd_d    = '0;
               tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
               state_d = S_RECOVER;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_WAIT_HI: begin
            // Completion takes priority over a simultaneous watchdog expiry.
            if (spi_ss) begin
               sample_d = spi_word[DATA_LSB +: 8];
               state_d  = S_CAPTURE;
            end else if (wd_q == WD_W'(XFER_TIMEOUT - 1)) begin
               wd_d    = '0;
               tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
               state_d = S_RECOVER;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_CAPTURE: begin
`ifdef LIGHT_AVG_EN
            level_d = 8'((10'(sample_q) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2])) >> 2);
            hist_d  = {hist_q[1:0], sample_q};
`else
            level_d = sample_q;
`endif
            led_d   = thermo(level_d[7:5]);
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         S_RECOVER: begin
            if (wd_q == WD_W'(RECOVER_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      start_d = (state_d == S_START);
      rst_d   = (state_d == S_RECOVER);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wd_q     <= '0;
         sample_q <= '0;
         level_q  <= '0;
         led_q    <= 8'h01;
         valid_q  <= 1'b0;
         tcnt_q   <= '0;
         start_q  <= 1'b0;
         rst_q    <= 1'b1;
`ifdef LIGHT_AVG_EN
         hist_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
         sample_q <= sample_d;
         level_q  <= level_d;
         led_q    <= led_d;
         valid_q  <= valid_d;
         tcnt_q   <= tcnt_d;
         start_q  <= start_d;
         rst_q    <= rst_d;
`ifdef LIGHT_AVG_EN
         hist_q   <= hist_d;
`endif
      end
   end

   assign spi_start   = start_q;
   assign spi_rst     = rst_q;
   assign light_level = level_q;
   assign level_valid = valid_q;
   assign led_bar     = led_q;
   assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_light_sample_scheduler.sv
// Bench for light_sample_scheduler: behavioural SPI slave-select model plus a scoreboard of
// expected light_level/led_bar values pushed when a transfer completes.
module tb_light_sample_scheduler;

   localparam int unsigned PER  = 64;
   localparam int unsigned ACK  = 16;
   localparam int unsigned XFER = 300;
   localparam int unsigned REC  = 4;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        spi_start;
   logic        spi_rst;
   logic        spi_ss;
   logic [15:0] spi_word;
   logic [7:0]  light_level;
   logic        level_valid;
   logic [7:0]  led_bar;
   logic [7:0]  timeout_cnt;

   light_sample_scheduler #(
      .PERIOD_CYCLES (PER),
      .ACK_TIMEOUT   (ACK),
      .XFER_TIMEOUT  (XFER),
      .RECOVER_CYCLES(REC),
      .DATA_LSB      (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .spi_start  (spi_start),
      .spi_rst    (spi_rst),
      .spi_ss     (spi_ss),
      .spi_word   (spi_word),
      .light_level(light_level),
      .level_valid(level_valid),
      .led_bar    (led_bar),
      .timeout_cnt(timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          hold;
      logic [7:0]  sample;
   } vec_t;

   typedef struct {
      logic [7:0] level;
      logic [7:0] led;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] last_level = 8'h00;
`ifdef LIGHT_AVG_EN
   logic [7:0] bh[3];
`endif

   // Model configuration, read by the SPI model when it sees a start pulse.
   logic        model_en   = 1'b0;
   logic        cfg_never  = 1'b0;
   logic        cfg_abort  = 1'b0;
   logic [15:0] cfg_word   = 16'h0000;
   logic [7:0]  cfg_sample = 8'h00;
   int          cfg_hold   = 1;

   // Monitor statistics.
   int   cyc = 0, n_start = 0, n_rst = 0, n_valid = 0;
   int   start_cyc = 0, rst_rise = 0;
   logic rst_prev = 1'b0;

   function automatic logic [7:0] therm_m(input logic [7:0] lvl);
      logic [15:0] t;
      t = (16'd1 << (int'(lvl[7:5]) + 1)) - 16'd1;
      return t[7:0];
   endfunction

   function automatic void push_exp(input logic [7:0] s);
      exp_t e;
      logic [7:0] lvl;
`ifdef LIGHT_AVG_EN
      int sum;
      sum = int'(s) + int'(bh[0]) + int'(bh[1]) + int'(bh[2]);
      lvl = 8'(sum / 4);
      bh[2] = bh[1];
      bh[1] = bh[0];
      bh[0] = s;
`else
      lvl = s;
`endif
      e.level = lvl;
      e.led   = therm_m(lvl);
      last_level = lvl;
      sb.push_back(e);
   endfunction

   function automatic void clear_model();
`ifdef LIGHT_AVG_EN
      bh[0] = 8'h00;
      bh[1] = 8'h00;
      bh[2] = 8'h00;
`endif
      last_level = 8'h00;
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int budget, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (level_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no level_valid within %0d cycles, expected one", name, budget);
      end
   endtask

   task automatic wait_sig(input int budget, input bit want_start, input bit level, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((want_start ? spi_start : spi_rst) == level) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: signal not at %0d within %0d cycles", name, level, budget);
      end
   endtask

   // SPI master model: drop SS one cycle after start, hold it low, then release.
   initial begin
      spi_ss   = 1'b1;
      spi_word = 16'h0000;
      forever begin
         @(negedge clk);
         if (model_en && spi_start && !cfg_never) begin
            automatic int         m_hold   = cfg_hold;
            automatic logic [7:0] m_sample = cfg_sample;
            automatic logic       m_abort  = cfg_abort;
            spi_word = cfg_word;
            @(negedge clk);
            spi_ss = 1'b0;
            repeat (m_hold) @(negedge clk);
            spi_ss = 1'b1;
            // SS rising on or before the last watchdog cycle completes the transfer.
            if (!m_abort && m_hold <= int'(XFER)) push_exp(m_sample);
         end
      end
   end

   // Output monitor and scoreboard consumer.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (spi_start) begin
            n_start++;
            start_cyc = cyc;
         end
         if (spi_rst) begin
            if (!rst_prev) rst_rise = cyc;
            n_rst++;
         end
         rst_prev = spi_rst;
         if (spi_start && spi_rst) begin
            checks++;
            errors++;
            $display("FAIL start_rst_overlap: spi_start=%b spi_rst=%b, expected not both", spi_start, spi_rst);
         end
         if (level_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: level_valid=1 light_level=%h, expected no update", light_level);
            end else begin
               automatic exp_t e = sb.pop_front();
               check8("sb_level", light_level, e.level);
               check8("sb_led", led_bar, e.led);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tab[8];
      int   r0, s0, v0;
      tab[0] = '{16'h0FE0, 200, 8'h7F};
      tab[1] = '{16'h0000,   5, 8'h00};
      tab[2] = '{16'h1FE0,  12, 8'hFF};
      tab[3] = '{16'h1000,   3, 8'h80};
      tab[4] = '{16'hE01F,   7, 8'h00};
      tab[5] = '{16'h0AA0,  30, 8'h55};
      tab[6] = '{16'h1540,   1, 8'hAA};
      tab[7] = '{16'h0C00,   9, 8'h60};
      clear_model();

      // Reset state and idle behaviour with enable low.
      reset  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check8("rst_spi_rst", 8'(spi_rst), 8'h01);
      check8("rst_spi_start", 8'(spi_start), 8'h00);
      check8("rst_level", light_level, 8'h00);
      check8("rst_valid", 8'(level_valid), 8'h00);
      check8("rst_led", led_bar, 8'h01);
      check8("rst_tcnt", timeout_cnt, 8'h00);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check8("rst_release_spi_rst", 8'(spi_rst), 8'h00);
      r0 = n_rst;
      s0 = n_start;
      repeat (2000) @(negedge clk);
      check_int("idle_no_start", n_start - s0, 0);
      check_int("idle_no_rst", n_rst - r0, 0);
      check8("idle_led", led_bar, 8'h01);
      check8("idle_level", light_level, 8'h00);

      // Table-driven transfers.
      model_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cfg_word   = tab[i].word;
         cfg_hold   = tab[i].hold;
         cfg_sample = tab[i].sample;
         enable     = 1'b1;
         wait_valid(int'(PER) + tab[i].hold + 40, $sformatf("vec%0d_done", i));
      end
      check8("vec_tcnt", timeout_cnt, 8'h00);

      // No SS acknowledge: recovery pulse timing and length.
      cfg_never = 1'b1;
      r0 = n_rst;
      wait_sig(int'(PER) + 60, 1'b0, 1'b1, "ack_rst_rise");
      check_int("ack_rst_latency", rst_rise - start_cyc, int'(ACK) + 1);
      wait_sig(20, 1'b0, 1'b0, "ack_rst_fall");
      check_int("ack_rst_len", n_rst - r0, int'(REC));
      check8("ack_tcnt", timeout_cnt, 8'h01);
      check8("ack_level_kept", light_level, last_level);
      check8("ack_led_kept", led_bar, therm_m(last_level));
      cfg_never  = 1'b0;
      cfg_word   = 16'h0AA0;
      cfg_sample = 8'h55;
      cfg_hold   = 6;
      wait_valid(int'(PER) * 2 + 40, "after_ack_recovery");

      // SS rises on the exact watchdog expiry cycle: completion wins.
      cfg_word   = 16'h1540;
      cfg_sample = 8'hAA;
      cfg_hold   = int'(XFER);
      wait_valid(int'(PER) + int'(XFER) + 40, "xfer_exact_expiry");
      check8("xfer_exact_tcnt", timeout_cnt, 8'h01);

      // SS stuck one cycle longer: recovery.
      cfg_hold = int'(XFER) + 1;
      v0 = n_valid;
      wait_sig(int'(PER) + int'(XFER) + 40, 1'b0, 1'b1, "xfer_stuck_rst");
      wait_sig(20, 1'b0, 1'b0, "xfer_stuck_rst_fall");
      check8("xfer_stuck_tcnt", timeout_cnt, 8'h02);
      check8("xfer_stuck_level", light_level, last_level);
      check_int("xfer_stuck_no_valid", n_valid - v0, 0);

      // enable dropped mid-transfer: transfer still completes, then idle.
      cfg_word   = 16'h1FE0;
      cfg_sample = 8'hFF;
      cfg_hold   = 60;
      wait_sig(int'(PER) + 40, 1'b1, 1'b1, "en_drop_start");
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_valid(100, "en_drop_done");
      s0 = n_start;
      repeat (200) @(negedge clk);
      check_int("en_drop_idle", n_start - s0, 0);

      // Reset mid-transfer aborts it.
      cfg_word   = 16'h1000;
      cfg_sample = 8'h80;
      cfg_hold   = 100;
      cfg_abort  = 1'b1;
      enable     = 1'b1;
      wait_sig(int'(PER) + 40, 1'b1, 1'b1, "abort_start");
      enable = 1'b0;
      repeat (20) @(negedge clk);
      v0 = n_valid;
      reset = 1'b0;
      @(negedge clk);
      check8("abort_rst_high", 8'(spi_rst), 8'h01);
      check8("abort_start_low", 8'(spi_start), 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      clear_model();
      repeat (150) @(negedge clk);
      check_int("abort_no_valid", n_valid - v0, 0);
      check8("abort_level", light_level, 8'h00);
      check8("abort_led", led_bar, 8'h01);
      check8("abort_tcnt", timeout_cnt, 8'h00);
      check8("abort_spi_rst", 8'(spi_rst), 8'h00);
      cfg_abort  = 1'b0;
      cfg_word   = 16'h0FE0;
      cfg_sample = 8'h7F;
      cfg_hold   = 20;
      enable     = 1'b1;
      wait_valid(int'(PER) + 60, "after_abort");

`ifdef LIGHT_AVG_EN
      // Averaging ramp from a cleared history.
      begin
         logic [7:0] avg_exp[4];
         avg_exp[0] = 8'h20;
         avg_exp[1] = 8'h40;
         avg_exp[2] = 8'h60;
         avg_exp[3] = 8'h80;
         enable = 1'b0;
         reset  = 1'b0;
         repeat (3) @(negedge clk);
         reset = 1'b1;
         clear_model();
         cfg_word   = 16'h1000;
         cfg_sample = 8'h80;
         cfg_hold   = 8;
         enable     = 1'b1;
         for (int k = 0; k < 4; k++) begin
            wait_valid(int'(PER) + 40, $sformatf("avg%0d_done", k));
            check8($sformatf("avg%0d_level", k), light_level, avg_exp[k]);
         end
      end
`endif

      enable = 1'b0;
      repeat (20) @(negedge clk);
      check_int("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
